// File: rtl/conv1d_lane_engine_if.sv
// CFU command/response handshake between the bus adapter (master) and the conv1d engine (slave).
interface conv1d_lane_engine_if #(
   parameter int INT32_SIZE = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [6:0]            cmd_id;
   logic [INT32_SIZE-1:0] inp0;
   logic [INT32_SIZE-1:0] inp1;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [INT32_SIZE-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_id, inp0, inp1, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_id, inp0, inp1, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/conv1d_lane_engine.sv
// int8 1-D convolution MAC engine: circular KERNEL_LENGTH-slot input window, weight buffer,
// LANES channel MACs per cycle, bias add, single-outstanding CFU cmd/rsp handshake.
module conv1d_lane_mac #(
   parameter int BYTE_SIZE  = 8,
   parameter int INT32_SIZE = 32
) (
   input  logic                  en,
   input  logic [BYTE_SIZE-1:0]  w,
   input  logic [BYTE_SIZE-1:0]  x,
   input  logic [INT32_SIZE-1:0] offset,
   output logic [INT32_SIZE-1:0] prod
);
   logic [INT32_SIZE-1:0] w_ext, x_ext;

   always_comb begin
      w_ext = {{(INT32_SIZE-BYTE_SIZE){w[BYTE_SIZE-1]}}, w};
      x_ext = {{(INT32_SIZE-BYTE_SIZE){x[BYTE_SIZE-1]}}, x} + offset;
      // low word of the product is identical for signed and unsigned operands
      prod  = en ? w_ext * x_ext : '0;
   end
endmodule

module conv1d_lane_engine #(
   parameter int BYTE_SIZE          = 8,
   parameter int INT32_SIZE         = 32,
   parameter int KERNEL_LENGTH      = 8,
   parameter int MAX_INPUT_CHANNELS = 128,
   parameter int LANES              = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   conv1d_lane_engine_if.slave  bus
);
   localparam int DEPTH = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(MAX_INPUT_CHANNELS + 1);
   localparam int SW    = (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1;

   localparam logic [6:0] CMD_WR_IN   = 7'd10;
   localparam logic [6:0] CMD_WR_W    = 7'd11;
   localparam logic [6:0] CMD_WR_IN4  = 7'd12;
   localparam logic [6:0] CMD_RD_IN   = 7'd13;
   localparam logic [6:0] CMD_RD_W    = 7'd14;
   localparam logic [6:0] CMD_WR_W4   = 7'd15;
   localparam logic [6:0] CMD_OFFSET  = 7'd20;
   localparam logic [6:0] CMD_BIAS    = 7'd21;
   localparam logic [6:0] CMD_DEPTH   = 7'd26;
   localparam logic [6:0] CMD_COMPUTE = 7'd41;
   localparam logic [6:0] CMD_GET_ACC = 7'd43;
   localparam logic [6:0] CMD_START_X = 7'd44;

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RESP} state_e;

   state_e                state_q, state_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [INT32_SIZE-1:0] rsp_data_q, rsp_data_d;
   logic [INT32_SIZE-1:0] offset_q, offset_d;
   logic [INT32_SIZE-1:0] bias_q, bias_d;
   logic [INT32_SIZE-1:0] acc_q, acc_d;
   logic [CW-1:0]         depth_q, depth_d;
   logic [CW-1:0]         c_q, c_d;
   logic [SW-1:0]         start_x_q, start_x_d;
   logic [SW-1:0]         fx_q, fx_d;
   logic [SW-1:0]         slot_q, slot_d;
   logic [AW-1:0]         w_base_q, w_base_d;
   logic [AW-1:0]         in_base_q, in_base_d;

   logic [BYTE_SIZE-1:0]  input_buf_q  [DEPTH];
   logic [BYTE_SIZE-1:0]  weight_buf_q [DEPTH];

   // byte write ports, shared by single and packed writes (port 0 also serves reads)
   logic [3:0]                wr_ok, wr_in_en, wr_w_en;
   logic [3:0][AW-1:0]        wr_addr;
   logic [3:0][BYTE_SIZE-1:0] wr_byte;

   always_comb begin
      logic [INT32_SIZE:0] wr_full;
      wr_full = '0;
      for (int i = 0; i < 4; i++) begin
         wr_full    = {1'b0, bus.inp0} + (INT32_SIZE+1)'(i);
         wr_ok[i]   = wr_full < (INT32_SIZE+1)'(DEPTH);
         wr_addr[i] = wr_full[AW-1:0];
         wr_byte[i] = bus.inp1[BYTE_SIZE*i +: BYTE_SIZE];
      end
   end

   function automatic logic [INT32_SIZE-1:0] sext(input logic [BYTE_SIZE-1:0] b);
      return {{(INT32_SIZE-BYTE_SIZE){b[BYTE_SIZE-1]}}, b};
   endfunction

   logic [LANES-1:0]                 lane_en;
   logic [LANES-1:0][AW-1:0]         lane_w_addr, lane_in_addr;
   logic [LANES-1:0][BYTE_SIZE-1:0]  lane_w, lane_x;
   logic [LANES-1:0][INT32_SIZE-1:0] lane_prod;
   logic [INT32_SIZE-1:0]            lane_sum;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [CW:0] ch;
      assign ch              = {1'b0, c_q} + (CW+1)'(l);
      assign lane_en[l]      = ch < {1'b0, depth_q};
      assign lane_w_addr[l]  = w_base_q + AW'(ch);
      assign lane_in_addr[l] = in_base_q + AW'(ch);
      assign lane_w[l]       = weight_buf_q[lane_w_addr[l]];
      assign lane_x[l]       = input_buf_q[lane_in_addr[l]];

      conv1d_lane_mac #(.BYTE_SIZE(BYTE_SIZE), .INT32_SIZE(INT32_SIZE)) u_mac (
         .en     (lane_en[l]),
         .w      (lane_w[l]),
         .x      (lane_x[l]),
         .offset (offset_q),
         .prod   (lane_prod[l])
      );
   end

   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < LANES; l++) lane_sum = lane_sum + lane_prod[l];
   end

   logic [CW:0] c_next;
   logic        row_done, last_beat;
   assign c_next    = {1'b0, c_q} + (CW+1)'(LANES);
   assign row_done  = c_next >= {1'b0, depth_q};
   assign last_beat = (depth_q == '0) || (row_done && fx_q == SW'(KERNEL_LENGTH - 1));

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      offset_d    = offset_q;
      bias_d      = bias_q;
      acc_d       = acc_q;
      depth_d     = depth_q;
      c_d         = c_q;
      start_x_d   = start_x_q;
      fx_d        = fx_q;
      slot_d      = slot_q;
      w_base_d    = w_base_q;
      in_base_d   = in_base_q;
      wr_in_en    = '0;
      wr_w_en     = '0;
      case (state_q)
         S_IDLE: if (bus.cmd_valid) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            case (bus.cmd_id)
               CMD_WR_IN:   wr_in_en = {3'b000, wr_ok[0]};
               CMD_WR_W:    wr_w_en  = {3'b000, wr_ok[0]};
               CMD_WR_IN4:  wr_in_en = wr_ok;
               CMD_WR_W4:   wr_w_en  = wr_ok;
               CMD_RD_IN:   rsp_data_d = wr_ok[0] ? sext(input_buf_q[wr_addr[0]]) : '0;
               CMD_RD_W:    rsp_data_d = wr_ok[0] ? sext(weight_buf_q[wr_addr[0]]) : '0;
               CMD_OFFSET:  offset_d = bus.inp1;
               CMD_BIAS:    bias_d   = bus.inp1;
               CMD_DEPTH: begin
                  if (bus.inp1[INT32_SIZE-1])
                     depth_d = '0;
                  else if (bus.inp1 > INT32_SIZE'(MAX_INPUT_CHANNELS))
                     depth_d = CW'(MAX_INPUT_CHANNELS);
                  else
                     depth_d = CW'(bus.inp1);
               end
               CMD_START_X: start_x_d = SW'(bus.inp1 % INT32_SIZE'(KERNEL_LENGTH));
               CMD_COMPUTE: begin
                  state_d     = S_COMPUTE;
                  rsp_valid_d = 1'b0;
                  acc_d       = bias_q;
                  c_d         = '0;
                  fx_d        = '0;
                  slot_d      = start_x_q;
                  w_base_d    = '0;
                  in_base_d   = AW'(start_x_q) * AW'(depth_q);
               end
               CMD_GET_ACC: rsp_data_d = acc_q;
               default: ;
            endcase
         end
         S_COMPUTE: begin
            acc_d = acc_q + lane_sum;
            if (row_done) begin
               c_d      = '0;
               fx_d     = fx_q + 1'b1;
               w_base_d = w_base_q + AW'(depth_q);
               // slot base steps by depth and wraps back to 0 instead of a modulo
               if (slot_q == SW'(KERNEL_LENGTH - 1)) begin
                  slot_d    = '0;
                  in_base_d = '0;
               end else begin
                  slot_d    = slot_q + 1'b1;
                  in_base_d = in_base_q + AW'(depth_q);
               end
            end else begin
               c_d = c_q + CW'(LANES);
            end
            if (last_beat) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = acc_d;
            end
         end
         S_RESP: if (bus.rsp_ready) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         offset_q    <= '0;
         bias_q      <= '0;
         acc_q       <= '0;
         depth_q     <= '0;
         c_q         <= '0;
         start_x_q   <= '0;
         fx_q        <= '0;
         slot_q      <= '0;
         w_base_q    <= '0;
         in_base_q   <= '0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         offset_q    <= offset_d;
         bias_q      <= bias_d;
         acc_q       <= acc_d;
         depth_q     <= depth_d;
         c_q         <= c_d;
         start_x_q   <= start_x_d;
         fx_q        <= fx_d;
         slot_q      <= slot_d;
         w_base_q    <= w_base_d;
         in_base_q   <= in_base_d;
      end
   end

   // buffers keep their contents across reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_in_en[i]) input_buf_q[wr_addr[i]]  <= wr_byte[i];
            if (wr_w_en[i])  weight_buf_q[wr_addr[i]] <= wr_byte[i];
         end
      end
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_conv1d_lane_engine.sv
// Directed bench for conv1d_lane_engine: shadow buffers + reference conv model feed a response scoreboard.
module tb_conv1d_lane_engine;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv1d_lane_engine_if bus ();

   conv1d_lane_engine #(
      .BYTE_SIZE(8), .INT32_SIZE(32), .KERNEL_LENGTH(8), .MAX_INPUT_CHANNELS(128), .LANES(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] sb_q [$];
   logic [7:0]  m_in [1024];
   logic [7:0]  m_w  [1024];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sx8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] model(input int d, input int sx, input logic [31:0] off,
                                         input logic [31:0] bias);
      logic [31:0] acc;
      int xi;
      acc = bias;
      for (int fx = 0; fx < 8; fx++)
         for (int c = 0; c < d; c++) begin
            xi  = ((fx + sx) % 8) * d + c;
            acc = acc + sx8(m_w[fx*d + c]) * (sx8(m_in[xi]) + off);
         end
      return acc;
   endfunction

   task automatic xact(input logic [6:0] id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string tag);
      int n, lat, busy_bad;
      sb_q.push_back(exp);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_id    = id;
      bus.inp0      = a;
      bus.inp1      = b;
      n = 0;
      while (!bus.cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         bus.cmd_valid = 1'b0;
         void'(sb_q.pop_front());
         chk({tag, "_accept"}, {31'd0, bus.cmd_ready}, 32'd1);
         return;
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      lat      = 1;
      busy_bad = 0;
      while (!bus.rsp_valid && lat < 1000) begin
         if (bus.cmd_ready) busy_bad++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (bus.cmd_ready) busy_bad++;
      chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      chk({tag, "_data"}, bus.rsp_data, sb_q.pop_front());
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_cmd_ready_low"}, 32'(busy_bad), 32'd0);
   endtask

   task automatic wr4(input bit is_w, input logic [31:0] addr, input logic [31:0] word);
      longint ad;
      xact(is_w ? 7'd15 : 7'd12, addr, word, 32'd0, 1, is_w ? "wr_w4" : "wr_in4");
      for (int i = 0; i < 4; i++) begin
         ad = longint'(addr) + i;
         if (ad < 1024) begin
            if (is_w) m_w[int'(ad)] = word[8*i +: 8];
            else      m_in[int'(ad)] = word[8*i +: 8];
         end
      end
   endtask

   task automatic cfg(input logic [31:0] d, input logic [31:0] off, input logic [31:0] bias,
                      input logic [31:0] sx);
      xact(7'd26, 32'd0, d,    32'd0, 1, "cfg_depth");
      xact(7'd20, 32'd0, off,  32'd0, 1, "cfg_offset");
      xact(7'd21, 32'd0, bias, 32'd0, 1, "cfg_bias");
      xact(7'd44, 32'd0, sx,   32'd0, 1, "cfg_start_x");
   endtask

   initial begin
      logic [31:0] off, bias;
      int n;
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_id    = '0;
      bus.inp0      = '0;
      bus.inp1      = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_data",  bus.rsp_data, 32'd0);
      chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_acc_via_43_skipped_none", 32'(sb_q.size()), 32'd0);

      // T1: packed little-endian write, reads, out-of-range handling
      wr4(1'b0, 32'd0, 32'h0403_0201);
      for (int i = 0; i < 4; i++) xact(7'd13, 32'(i), 32'd0, 32'(i + 1), 1, "t1_rd");
      xact(7'd13, 32'd1024, 32'd0, 32'd0, 1, "t1_rd_oob");
      wr4(1'b0, 32'hFFFF_FFFF, 32'h5555_5555);
      xact(7'd13, 32'd0, 32'd0, 32'd1, 1, "t1_no_wrap");
      wr4(1'b1, 32'd1022, 32'hAABB_CCDD);
      xact(7'd14, 32'd1022, 32'd0, 32'hFFFF_FFDD, 1, "t1_rd_w_1022");
      xact(7'd14, 32'd1023, 32'd0, 32'hFFFF_FFCC, 1, "t1_rd_w_1023");
      xact(7'd11, 32'd1023, 32'h1234_567F, 32'd0, 1, "t1_wr_w");
      m_w[1023] = 8'h7F;
      xact(7'd14, 32'd1023, 32'd0, 32'h0000_007F, 1, "t1_rd_w_single");
      xact(7'd99, 32'd5, 32'd5, 32'd0, 1, "t1_unknown");

      // random contents over both full buffers
      for (int a = 0; a < 1024; a += 4) begin
         wr4(1'b0, 32'(a), $urandom);
         wr4(1'b1, 32'(a), $urandom);
      end
      off  = $urandom;
      bias = $urandom;
      cfg(32'd7, off, bias, 32'd3);
      xact(7'd41, 32'd0, 32'd0, model(7, 3, off, bias), 8*2 + 1, "rand_d7");
      xact(7'd43, 32'd0, 32'd0, model(7, 3, off, bias), 1, "rand_d7_acc");
      xact(7'd26, 32'd0, 32'd200, 32'd0, 1, "cfg_depth_big");
      xact(7'd41, 32'd0, 32'd0, model(128, 3, off, bias), 8*32 + 1, "depth_clamp");
      xact(7'd26, 32'd0, 32'hFFFF_FFFB, 32'd0, 1, "cfg_depth_neg");
      xact(7'd41, 32'd0, 32'd0, bias, 2, "depth_zero");

      // T2: D=1, all ones
      wr4(1'b0, 32'd0, 32'h0101_0101);
      wr4(1'b0, 32'd4, 32'h0101_0101);
      wr4(1'b1, 32'd0, 32'h0101_0101);
      wr4(1'b1, 32'd4, 32'h0101_0101);
      cfg(32'd1, 32'd0, 32'd0, 32'd0);
      xact(7'd41, 32'd0, 32'd0, 32'd8, 9, "t2");

      // T3: D=5 spans a partial lane group
      for (int a = 0; a < 40; a += 4) begin
         wr4(1'b0, 32'(a), 32'hFDFD_FDFD);
         wr4(1'b1, 32'(a), 32'h0202_0202);
      end
      cfg(32'd5, 32'd5, 32'hFFFF_FFF6, 32'd0);
      xact(7'd41, 32'd0, 32'd0, 32'd150, 17, "t3");

      // T4: window rotation
      wr4(1'b0, 32'd0, 32'h0000_0001);
      wr4(1'b0, 32'd4, 32'h0000_0000);
      wr4(1'b1, 32'd0, 32'h0700_0000);
      wr4(1'b1, 32'd4, 32'h0000_0000);
      cfg(32'd1, 32'd0, 32'd0, 32'd5);
      xact(7'd41, 32'd0, 32'd0, 32'd7, 9, "t4_sx5");
      xact(7'd44, 32'd0, 32'd13, 32'd0, 1, "t4_cfg_sx13");

      // T5: response held under rsp_ready=0
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      xact(7'd41, 32'd0, 32'd0, 32'd7, 9, "t5_sx13");
      bus.cmd_valid = 1'b1;
      bus.cmd_id    = 7'd43;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("t5_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
         chk("t5_hold_data",  bus.rsp_data, 32'd7);
         chk("t5_hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_released", {31'd0, bus.rsp_valid}, 32'd0);
      xact(7'd43, 32'd0, 32'd0, 32'd7, 1, "t5_acc");

      // T6: reset during compute aborts the command
      @(posedge clk);
      #1;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_id    = 7'd41;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      chk("t6_busy", {31'd0, bus.cmd_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("t6_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("t6_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
      n = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) n++;
      end
      chk("t6_no_rsp", 32'(n), 32'd0);
      xact(7'd43, 32'd0, 32'd0, 32'd0, 1, "t6_acc");

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
